btb_update_ctrl: RTL
====================

Name: btb_update_ctrl

Overview:
- Write-side controller for the 8-set, 2-way branch target buffer storage.
- Accepts resolved-branch records from execute through a small FIFO.
- For each record: reads the current set over the storage's update port, computes hit/miss, counter, target and LRU changes, then writes the new set back over the storage's write port.
- Sits between the execute-stage branch resolution unit and the BTB storage; the fetch-side read port is untouched.

Parameters:
- FIFO_DEPTH, 4, resolved-branch queue depth (power of 2, >=2).
- CNT_W, 16, width of the saturating allocation counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  resolved branch record valid
- in_ready  output  1  FIFO can accept (= !full)
- in_pc  input  32  branch PC; [1:0] ignored, index=[4:2], tag=[31:5]
- in_taken  input  1  resolved direction
- in_target  input  32  resolved target
- update_index  output  3  set index presented to storage update port
- update_set  input  128  set contents returned combinationally for update_index
- write_en  output  1  one-cycle write strobe to storage
- write_index  output  3  set index to write
- write_set  output  128  new set contents
- busy  output  1  state!=IDLE or FIFO non-empty
- alloc_count  output  CNT_W  saturating count of allocations

Behaviour:
- Set layout:
  - [127]: LRU, value = victim way.
  - [126:124]: reserved, written 0.
  - Way1: [123:62]. Way0: [61:0].
- Way layout (62b):
  - [61]: valid
  - [60:34]: tag (27b)
  - [33:2]: target
  - [1:0]: 2-bit saturating counter
- Reset state: FIFO empty, state IDLE, write_en=0, write_index=0, write_set=0, update_index=0, alloc_count=0, in_ready=1, busy=0.
- Reset mid-operation: pending write and all queued records are dropped. write_en is 0 in the cycle after the reset edge.
- FIFO: push on in_valid&&in_ready. in_ready=!full and does not depend on a same-cycle pop. Pointers wrap mod FIFO_DEPTH; occupancy count is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, LOOKUP, WRITE.
- IDLE: if FIFO non-empty, pop head into work register, go to LOOKUP; else stay.
- LOOKUP:
  - update_index = work_pc[4:2]; compare tag with both ways (valid && tag equal). Way0 has priority if both match.
  - Hit way w: counter +1 if taken (saturate 3), -1 if not taken (saturate 0). If taken, target <= in_target; if not taken, target is unchanged. LRU <= ~w. Register write_set/write_index, go to WRITE.
  - Miss, not taken: no write, go to IDLE.
  - Miss, taken: victim = way0 if invalid, else way1 if invalid, else way LRU. Victim <= {valid=1, tag, target, ctr=2'b10}; LRU <= ~victim. Other way unchanged. alloc_count++ (saturating). Go to WRITE.
- WRITE: write_en=1 for exactly this cycle, with registered write_index/write_set. Next state is LOOKUP (with pop) if FIFO non-empty, else IDLE.
- write_en is 0 in IDLE and LOOKUP.
- update_index holds work_pc[4:2] in all states.
- Latency: record accepted at edge E0 -> LOOKUP cycle after E1 -> write_en high in cycle after E2. Steady-state throughput is 1 record per 2 cycles.
- Same-index back-to-back records: a LOOKUP after WRITE sees post-write contents, because the storage commits at the WRITE-ending edge. No forwarding is needed.
- Reserved bits [126:124] are forced to 0 on every write, regardless of update_set.

Test Plan:
- Reset, then pc=0x00001004 taken target=0x00002000 into zero set -> write_index=1; way0 valid=1, tag=0x80, target=0x2000, ctr=2; way1=0; [127]=1; alloc_count=1; write_en high exactly 1 cycle, 3 cycles after accept.
- Same pc not-taken x3 after allocation -> ctr goes 2->1->0->0; target stays 0x2000; [127]=1 each write.
- Set 1 with both ways valid, LRU=0, new tag miss taken -> way0 replaced, way1 bits unchanged, [127]=1; a miss not-taken to a different set -> no write_en, alloc_count unchanged.
- Push FIFO_DEPTH+1 records with no stalls -> in_ready=0 after 4 pending; every accepted record gets exactly one LOOKUP, in order; busy drops only after the last WRITE.
- Assert rst during WRITE with 2 records queued -> write_en=0 the next cycle, FIFO empty, busy=0, alloc_count=0; no further writes.
- Two taken records to same index (pc=0x20, tags differ) back-to-back -> second LOOKUP sees first allocation; second write fills way1 and sets [127]=0.

Source files
------------

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_ctrl
// Purpose  : Write-side controller for the 8-set, 2-way BTB. Queues resolved
//            branches, read-modify-writes one storage set per record.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic             in_taken,
  input  logic [31:0]      in_target,
  output logic [2:0]       update_index,
  input  logic [127:0]     update_set,
  output logic             write_en,
  output logic [2:0]       write_index,
  output logic [127:0]     write_set,
  output logic             busy,
  output logic [CNT_W-1:0] alloc_count
);

  localparam int         c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOOKUP = 2'd1;
  localparam logic [1:0] c_WRITE  = 2'd2;
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(FIFO_DEPTH);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               w_push;
  logic               w_pop;
  logic               w_nonempty;

  logic [31:2]        r_fifo_pc     [FIFO_DEPTH];
  logic               r_fifo_taken  [FIFO_DEPTH];
  logic [31:0]        r_fifo_target [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic [31:2]        r_work_pc;
  logic               r_work_taken;
  logic [31:0]        r_work_target;
  logic [2:0]         r_write_index;
  logic [127:0]       r_write_set;
  logic [CNT_W-1:0]   r_alloc;

  logic [61:0]        w_way0;
  logic [61:0]        w_way1;
  logic [26:0]        w_tag;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_victim;
  logic               w_sel;
  logic [61:0]        w_old;
  logic [1:0]         w_ctr;
  logic [31:0]        w_tgt;
  logic [61:0]        w_new_way;
  logic [127:0]       w_new_set;
  logic               w_unused_bits;

  assign w_unused_bits = ^{in_pc[1:0], update_set[126:124]};
  assign w_nonempty    = (r_count != '0);
  assign w_push        = in_valid && in_ready;

  // Lookup datapath: update_set is the current contents of the work set.
  assign w_way0   = update_set[61:0];
  assign w_way1   = update_set[123:62];
  assign w_tag    = r_work_pc[31:5];
  assign w_hit0   = w_way0[61] && (w_way0[60:34] == w_tag);
  assign w_hit1   = w_way1[61] && (w_way1[60:34] == w_tag);
  assign w_hit    = w_hit0 || w_hit1;
  assign w_victim = !w_way0[61] ? 1'b0 : (!w_way1[61] ? 1'b1 : update_set[127]);
  assign w_sel    = w_hit ? !w_hit0 : w_victim;
  assign w_old    = w_sel ? w_way1 : w_way0;

  always_comb begin
    w_ctr = 2'b10;
    if (w_hit) begin
      if (r_work_taken) w_ctr = (w_old[1:0] == 2'b11) ? 2'b11 : w_old[1:0] + 2'b01;
      else              w_ctr = (w_old[1:0] == 2'b00) ? 2'b00 : w_old[1:0] - 2'b01;
    end
  end

  assign w_tgt     = (w_hit && !r_work_taken) ? w_old[33:2] : r_work_target;
  assign w_new_way = {1'b1, w_tag, w_tgt, w_ctr};
  assign w_new_set = {~w_sel, 3'b000,
                      w_sel ? w_new_way : w_way1,
                      w_sel ? w_way0    : w_new_way};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_nonempty) begin
          w_pop        = 1'b1;
          w_next_state = c_LOOKUP;
        end
      end
      c_LOOKUP: w_next_state = (w_hit || r_work_taken) ? c_WRITE : c_IDLE;
      c_WRITE: begin
        w_pop        = w_nonempty;
        w_next_state = w_nonempty ? c_LOOKUP : c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    write_en = (r_state == c_WRITE);
    busy     = (r_state != c_IDLE) || w_nonempty;
    in_ready = (r_count != c_FULL);
  end

  assign update_index = r_work_pc[4:2];
  assign write_index  = r_write_index;
  assign write_set    = r_write_set;
  assign alloc_count  = r_alloc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]     <= in_pc[31:2];
      r_fifo_taken[r_wr_ptr]  <= in_taken;
      r_fifo_target[r_wr_ptr] <= in_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work_pc     <= '0;
      r_work_taken  <= 1'b0;
      r_work_target <= '0;
      r_write_index <= '0;
      r_write_set   <= '0;
      r_alloc       <= '0;
    end else begin
      if (w_pop) begin
        r_work_pc     <= r_fifo_pc[r_rd_ptr];
        r_work_taken  <= r_fifo_taken[r_rd_ptr];
        r_work_target <= r_fifo_target[r_rd_ptr];
      end
      if ((r_state == c_LOOKUP) && (w_hit || r_work_taken)) begin
        r_write_index <= r_work_pc[4:2];
        r_write_set   <= w_new_set;
        if (!w_hit && (r_alloc != {CNT_W{1'b1}})) r_alloc <= r_alloc + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
